mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
Iterative multiply/divide unit in the EX stage, directly downstream of the register file. It consumes the two register read operands and computes MULT, MULTU, DIV and DIVU into architectural HI/LO registers. Computation takes a fixed 32 iterations on a single Clock; Busy tells the pipeline control to stall while the unit works. MFHI/MFLO read Hi/Lo directly, and MTHI/MTLO write them through dedicated strobes.

Parameters:
WIDTH, 32, operand width and HI/LO width; iteration count equals WIDTH.

Ports:
Clock  in  1  system clock; all state updates on rising edge
Reset  in  1  synchronous, active-low reset (Reset=0 at a rising edge resets the block)
Start  in  1  launch operation; sampled only when Busy=0
Op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
OpA  in  WIDTH  rs operand (multiplicand / dividend), from ReadData1
OpB  in  WIDTH  rt operand (multiplier / divisor), from ReadData2
MoveToHi  in  1  MTHI strobe, Hi <= OpA
MoveToLo  in  1  MTLO strobe, Lo <= OpA
Busy  out  1  operation in progress; combinational from state != IDLE
Done  out  1  one-cycle pulse; Hi/Lo hold the new result in this cycle
Hi  out  WIDTH  HI register (product high word / remainder)
Lo  out  WIDTH  LO register (product low word / quotient)

Behaviour:
- Reset (Reset=0 at an edge): state=IDLE, Hi=0, Lo=0, Done=0, iteration counter=0, working registers cleared. Reset takes priority over every other input and aborts any operation in flight.
- States:
  - IDLE: Start=1 at edge E0 latches |OpA|, |OpB| (raw values for unsigned ops) and result signs, clears the counter, and moves to RUN. Otherwise stays in IDLE.
  - RUN: one iteration per edge (E1..E32), then moves to FIX. For MULT*, one shift-add step on a 2*WIDTH accumulator. For DIV*, one restoring shift-subtract step.
  - FIX (edge E33): applies signs, writes Hi/Lo, sets Done=1 for one cycle, returns to IDLE.
- Timing: Busy=1 in cycles 0..32, i.e. the 33 cycles following E0. Done=1 and the new Hi/Lo are valid in cycle 33 with Busy=0. The earliest next Start is sampled at E34.
- Hi/Lo keep their previous values until FIX; intermediate values are never visible.
- Start while Busy=1 is ignored, with no queuing. MoveToHi/MoveToLo while Busy=1 are ignored.
- When IDLE: Start=1 together with MoveToHi or MoveToLo makes Start win and the move is dropped. MoveToHi and MoveToLo together write both registers.
- Signed multiply: product magnitude is negated when signA^signB. Full 64-bit two's complement result, Hi = bits 63:32.
- Signed divide:
  - Quotient is negated when signA^signB.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0 (wraps, no trap).
- Divide by zero (OpB=0, DIV or DIVU): Hi=OpA, Lo=0xFFFFFFFF. Latency is unchanged at 33 busy cycles; the result is forced in FIX.
- Op and OpA/OpB are only sampled at the Start edge; later changes have no effect.

Decomposition:
- mdu_pkg holds:
  - the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - the state encoding (IDLE, RUN, FIX)
  - the iteration count constant MDU_ITER=32
- Natural sub-module: mdu_step, the combinational per-iteration datapath (shift-add or shift-subtract-restore on accumulator/partial remainder). The FSM, counter, sign handling and HI/LO live in mult_div_unit.

Test Plan:
- MULTU OpA=0xFFFFFFFF, OpB=0xFFFFFFFF -> Done only in cycle 33 after Start, Busy high exactly 33 cycles, Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT OpA=0xFFFFFFFD (-3), OpB=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB (-21); MULTU same operands -> Hi=0x00000006, Lo=0xFFFFFFEB.
- DIV OpA=0xFFFFFFF9 (-7), OpB=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU 7/2 -> Lo=3, Hi=1.
- DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0; DIVU 5/0 -> Hi=5, Lo=0xFFFFFFFF, latency still 33.
- MoveToHi with OpA=0x1234 when idle -> Hi=0x1234 next cycle, Lo unchanged.
  - During Busy, Start and MoveToLo are ignored and the original result completes unchanged.
- Reset=0 at iteration 10 of a MULT -> next cycle Busy=0, Hi=Lo=0, no Done pulse.
  - A new Start afterwards completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - operation encodings on the Op port
//   - FSM state encoding
//   - iteration count (one iteration per operand bit)
package mdu_pkg;

  localparam int MDU_ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
//   is_div_i  : 1 = restoring shift-subtract step, 0 = shift-add step
//   acc_i     : 2*WIDTH working accumulator
//               multiply: {partial product high, remaining multiplier bits}
//               divide  : {partial remainder, remaining dividend / quotient bits}
//   operand_i : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_o     : accumulator after this iteration
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_ITER
) (
  input  logic                 is_div_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     operand_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // Multiply: add multiplicand into the upper half when the multiplier LSB
    // is set; the carry lands in bit WIDTH and is shifted back in below.
    sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    // Divide: bring the next dividend bit into the partial remainder.
    shifted = acc_i[2*WIDTH-1:WIDTH-1];
    // Only used when shifted >= divisor, so the result fits in WIDTH bits.
    diff    = shifted[WIDTH-1:0] - operand_i;

    if (!is_div_i)
      acc_o = {sum, acc_i[WIDTH-1:1]};
    else if (shifted >= {1'b0, operand_i})
      acc_o = {diff, acc_i[WIDTH-2:0], 1'b1};
    else
      acc_o = {shifted[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Operands are converted to magnitudes at Start, WIDTH iterations run on the
// unsigned magnitudes, and signs are applied in a final FIX cycle that also
// writes Hi/Lo and pulses Done.
//   Clock    : rising-edge clock
//   Reset    : synchronous, active-low; aborts any operation in flight
//   Start    : launch Op on OpA/OpB (sampled only when idle)
//   Op       : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   OpA/OpB  : rs / rt operands
//   MoveToHi : MTHI strobe (Hi <= OpA) when idle
//   MoveToLo : MTLO strobe (Lo <= OpA) when idle
//   Busy     : operation in progress (state != IDLE)
//   Done     : one-cycle pulse, Hi/Lo hold the new result
//   Hi/Lo    : product high/low word, or remainder/quotient
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_ITER
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             MoveToHi,
  input  logic             MoveToLo,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;   // negate product / quotient
  logic               neg_rem_q, neg_rem_d;   // negate remainder (dividend sign)
  logic               divz_q, divz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] step_acc;
  logic               st_div, st_signed, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i  (is_div_q),
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .acc_o     (step_acc)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    opa_d     = opa_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    st_div    = (Op == OP_DIV) || (Op == OP_DIVU);
    st_signed = (Op == OP_MULT) || (Op == OP_DIV);
    sa        = st_signed & OpA[WIDTH-1];
    sb        = st_signed & OpB[WIDTH-1];
    mag_a     = sa ? -OpA : OpA;
    mag_b     = sb ? -OpB : OpB;

    prod      = neg_res_q ? -acc_q : acc_q;
    quo       = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem       = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      IDLE: begin
        if (Start) begin
          // Multiply iterates over the multiplier in the low half; divide
          // shifts the dividend out of the low half into the remainder.
          acc_d     = {{WIDTH{1'b0}}, st_div ? mag_a : mag_b};
          opnd_d    = st_div ? mag_b : mag_a;
          opa_d     = OpA;
          is_div_d  = st_div;
          neg_res_d = sa ^ sb;
          neg_rem_d = sa;
          divz_d    = st_div && (OpB == '0);
          cnt_d     = '0;
          state_d   = RUN;
        end else begin
          if (MoveToHi) hi_d = OpA;
          if (MoveToLo) lo_d = OpA;
        end
      end
      RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        if (!is_div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (divz_q) begin
          hi_d = opa_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      opa_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      opa_q     <= opa_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign Busy = (state_q != IDLE);
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a vector table of operations with
// hand-computed Hi/Lo, plus sequences for moves, busy-time interference
// and mid-operation reset.
module tb_mult_div_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] OpA = '0;
  logic [31:0] OpB = '0;
  logic        MoveToHi = 1'b0;
  logic        MoveToLo = 1'b0;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
    .MoveToHi(MoveToHi), .MoveToLo(MoveToLo), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch one operation and follow it to Done. Sampling is on the falling
  // edge; cycle c is the c-th cycle after the Start edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit perturb, output logic [31:0] hi, output logic [31:0] lo,
                        output int busy_n, output int done_at, output int changed);
    logic [31:0] h0, l0;
    busy_n = 0; done_at = -1; changed = 0; hi = '0; lo = '0;
    @(negedge Clock);
    Start = 1'b1; Op = op; OpA = a; OpB = b;
    h0 = Hi; l0 = Lo;
    @(posedge Clock);
    for (int c = 0; c < 50; c++) begin
      @(negedge Clock);
      Start = 1'b0; MoveToHi = 1'b0; MoveToLo = 1'b0;
      if (perturb && c == 5) begin
        Start = 1'b1; Op = 2'b11; OpA = 32'hDEAD_BEEF; OpB = 32'h1;
        MoveToHi = 1'b1; MoveToLo = 1'b1;
      end
      if (perturb && c == 6) OpB = 32'h0;
      if (Busy) busy_n++;
      if (Done) begin
        done_at = c; hi = Hi; lo = Lo;
        break;
      end
      if (Hi !== h0 || Lo !== l0) changed++;
    end
    Start = 1'b0; MoveToHi = 1'b0; MoveToLo = 1'b0;
  endtask

  logic [31:0] rh, rl;
  int bn, da, chg, seen;

  initial begin
    vq.push_back('{"multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vq.push_back('{"mult_neg3x7",2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    vq.push_back('{"multu_fdx7", 2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'h0000_0006, 32'hFFFF_FFEB});
    vq.push_back('{"div_n7_2",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vq.push_back('{"divu_7_2",   2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003});
    vq.push_back('{"div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    vq.push_back('{"divu_5_0",   2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF});
    vq.push_back('{"div_7_n2",   2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
    vq.push_back('{"div_n8_0",   2'b10, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF});
    vq.push_back('{"mult_min2",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    vq.push_back('{"mult_zero",  2'b00, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000});
    vq.push_back('{"divu_big",   2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF});
    vq.push_back('{"multu_2p32", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000});
    vq.push_back('{"div_100_7",  2'b10, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E});

    // Reset state
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    chk("rst_busy", {31'b0, Busy}, 32'h0);
    chk("rst_done", {31'b0, Done}, 32'h0);
    chk("rst_hi", Hi, 32'h0);
    chk("rst_lo", Lo, 32'h0);

    // Vector table
    foreach (vq[i]) begin
      run_op(vq[i].op, vq[i].a, vq[i].b, 1'b0, rh, rl, bn, da, chg);
      chk({vq[i].name, "_hi"}, rh, vq[i].hi);
      chk({vq[i].name, "_lo"}, rl, vq[i].lo);
      chk({vq[i].name, "_busy_cycles"}, 32'(bn), 32'd33);
      chk({vq[i].name, "_done_cycle"}, 32'(da), 32'd33);
      chk({vq[i].name, "_no_early_update"}, 32'(chg), 32'd0);
      @(negedge Clock);
      chk({vq[i].name, "_done_one_cycle"}, {31'b0, Done}, 32'h0);
    end

    // MTHI alone, then MTHI+MTLO together (Hi=2, Lo=0xE from last vector)
    @(negedge Clock);
    MoveToHi = 1'b1; OpA = 32'h0000_1234;
    @(negedge Clock);
    MoveToHi = 1'b0;
    chk("mthi_hi", Hi, 32'h0000_1234);
    chk("mthi_lo_kept", Lo, 32'h0000_000E);
    MoveToHi = 1'b1; MoveToLo = 1'b1; OpA = 32'h0000_ABCD;
    @(negedge Clock);
    MoveToHi = 1'b0; MoveToLo = 1'b0;
    chk("mt_both_hi", Hi, 32'h0000_ABCD);
    chk("mt_both_lo", Lo, 32'h0000_ABCD);

    // Start with MoveToLo in the same cycle: Start wins, move dropped
    Start = 1'b1; MoveToLo = 1'b1; Op = 2'b01; OpA = 32'd2; OpB = 32'd3;
    @(negedge Clock);
    Start = 1'b0; MoveToLo = 1'b0; OpA = 32'h5555_5555;
    chk("start_win_busy", {31'b0, Busy}, 32'h1);
    chk("start_win_lo_kept", Lo, 32'h0000_ABCD);
    seen = 0;
    for (int c = 0; c < 50 && seen == 0; c++) begin
      @(negedge Clock);
      if (Done) seen = 1;
    end
    chk("start_win_done", 32'(seen), 32'd1);
    chk("start_win_hi", Hi, 32'h0);
    chk("start_win_lo", Lo, 32'd6);

    // Start/MTHI/MTLO and operand changes while busy are ignored
    run_op(2'b01, 32'd3, 32'd5, 1'b1, rh, rl, bn, da, chg);
    chk("busy_ign_hi", rh, 32'h0);
    chk("busy_ign_lo", rl, 32'd15);
    chk("busy_ign_cycles", 32'(bn), 32'd33);
    chk("busy_ign_done", 32'(da), 32'd33);
    chk("busy_ign_stable", 32'(chg), 32'd0);
    @(negedge Clock);
    chk("busy_ign_no_requeue", {31'b0, Busy}, 32'h0);

    // Reset around iteration 10 of a MULT aborts it
    @(negedge Clock);
    Start = 1'b1; Op = 2'b00; OpA = 32'hFFFF_FFFD; OpB = 32'd7;
    @(negedge Clock);
    Start = 1'b0;
    repeat (10) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    chk("abort_busy", {31'b0, Busy}, 32'h0);
    chk("abort_hi", Hi, 32'h0);
    chk("abort_lo", Lo, 32'h0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clock);
      if (Done) seen = 1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    run_op(2'b00, 32'd6, 32'hFFFF_FFF9, 1'b0, rh, rl, bn, da, chg);
    chk("after_abort_hi", rh, 32'hFFFF_FFFF);
    chk("after_abort_lo", rl, 32'hFFFF_FFD6);
    chk("after_abort_done", 32'(da), 32'd33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
